// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants and display helper for the timekeeper
// Provides field widths, per-field maximum values and the 24h -> 12h
// display conversion used by rtc_timekeeper.
package rtc_pkg;

  localparam int HOUR_W = 5;
  localparam int MS_W   = 6;

  localparam logic [MS_W-1:0]   SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0]   MIN_MAX = 6'd59;
  localparam logic [HOUR_W-1:0] H24_MAX = 5'd23;

  // 0 shows as 12 (midnight), 13..23 fold down to 1..11.
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h24);
    logic [HOUR_W-1:0] r;
    if (h24 == 5'd0) begin
      r = 5'd12;
    end else if (h24 > 5'd12) begin
      r = h24 - 5'd12;
    end else begin
      r = h24;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtl/rtc_prescaler.sv - divides clk down to a once-per-second tick
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset, counter to 0
//   clr  in  restart the second: counter to 0 on the next edge
//   tick out high in the cycle where the counter sits at TICK_DIV-1
module rtc_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc;

  assign tick = (presc == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - h:m:s timekeeper with load, alarm and 12/24h display
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mode_24h                      display format select (1 = 24h)
//   set_valid, set_hour/min/sec   validated time load
//   alarm_wr, alarm_hour/min      validated alarm load
//   alarm_en                      alarm enable level
//   hour, pm                      display hour and PM flag (combinational)
//   minute, second                registered time fields
//   tick, day_wrap, alarm_hit     one-cycle event strobes
//   set_err                       one-cycle strobe on a rejected load
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_24h,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  output logic [4:0] hour,
  output logic       pm,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       set_err
);

  logic [HOUR_W-1:0] h24;
  logic [MS_W-1:0]   min_r;
  logic [MS_W-1:0]   sec_r;
  logic [HOUR_W-1:0] al_h;
  logic [MS_W-1:0]   al_m;

  logic              presc_tick;
  logic              load_ok;
  logic              alarm_ok;

  logic [HOUR_W-1:0] h_nx;
  logic [MS_W-1:0]   min_nx;
  logic [MS_W-1:0]   sec_nx;
  logic              wrap_nx;
  logic              hit_nx;

  assign load_ok  = set_valid && (set_hour <= H24_MAX) &&
                    (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
  assign alarm_ok = alarm_wr && (alarm_hour <= H24_MAX) && (alarm_min <= MIN_MAX);

  // An accepted load restarts the second so the next tick is a full
  // TICK_DIV cycles later.
  rtc_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_ok),
    .tick (presc_tick)
  );

  // Time after one more second, with carries rippling up to the day.
  always_comb begin
    sec_nx  = sec_r + 6'd1;
    min_nx  = min_r;
    h_nx    = h24;
    wrap_nx = 1'b0;
    if (sec_r == SEC_MAX) begin
      sec_nx = '0;
      if (min_r == MIN_MAX) begin
        min_nx = '0;
        if (h24 == H24_MAX) begin
          h_nx    = '0;
          wrap_nx = 1'b1;
        end else begin
          h_nx = h24 + 5'd1;
        end
      end else begin
        min_nx = min_r + 6'd1;
      end
    end
  end

  // Only a tick landing on hh:mm:00 counts; loads take the other branch
  // below and so can never raise the alarm.
  assign hit_nx = alarm_en && (h_nx == al_h) && (min_nx == al_m) && (sec_nx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      h24       <= '0;
      min_r     <= '0;
      sec_r     <= '0;
      al_h      <= '0;
      al_m      <= '0;
      tick      <= 1'b0;
      day_wrap  <= 1'b0;
      alarm_hit <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      tick      <= 1'b0;
      day_wrap  <= 1'b0;
      alarm_hit <= 1'b0;
      set_err   <= (set_valid && !load_ok) || (alarm_wr && !alarm_ok);

      if (load_ok) begin
        h24   <= set_hour;
        min_r <= set_min;
        sec_r <= set_sec;
      end else if (presc_tick) begin
        h24       <= h_nx;
        min_r     <= min_nx;
        sec_r     <= sec_nx;
        tick      <= 1'b1;
        day_wrap  <= wrap_nx;
        alarm_hit <= hit_nx;
      end

      if (alarm_ok) begin
        al_h <= alarm_hour;
        al_m <= alarm_min;
      end
    end
  end

  assign minute = min_r;
  assign second = sec_r;
  assign hour   = mode_24h ? h24 : to_12h(h24);
  assign pm     = (h24 >= 5'd12);

endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised real-time timekeeper that generalises the team's free-running h:m:s counter. It adds a clock prescaler, runtime 12/24-hour display mode, a validated time-load port, a one-minute-resolution alarm, and tick/day-rollover strobes. It sits between the system clock domain and the display/bus-register logic. Time is held internally as 24-hour binary; the display format is derived from that value.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per second. Must be ≥ 1; with 1, every cycle is a tick.
- `CNT_W`, default $clog2(TICK_DIV) (minimum 1): prescaler counter width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `mode_24h`  in  1  1 = 24-hour display, 0 = 12-hour display; sampled every cycle
- `set_valid`  in  1  one-cycle load strobe for the time
- `set_hour`  in  5  hour to load, 24-hour encoding 0–23
- `set_min`  in  6  minute to load, 0–59
- `set_sec`  in  6  second to load, 0–59
- `alarm_wr`  in  1  one-cycle strobe that loads the alarm registers
- `alarm_hour`  in  5  alarm hour, 0–23
- `alarm_min`  in  6  alarm minute, 0–59
- `alarm_en`  in  1  alarm enable; level-sensitive
- `hour`  out  5  displayed hour: 0–23 when `mode_24h`=1, 1–12 when `mode_24h`=0
- `pm`  out  1  1 when the internal hour is ≥ 12; valid in both modes
- `minute`  out  6  0–59
- `second`  out  6  0–59
- `tick`  out  1  one-cycle pulse, the cycle in which seconds advance
- `day_wrap`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 advance
- `alarm_hit`  out  1  one-cycle pulse on an alarm match
- `set_err`  out  1  one-cycle pulse when a time or alarm load is rejected

## Operation
- Internal registers: `h24` (5 bits), `min_r` (6), `sec_r` (6), `presc` (`CNT_W`), `al_h` (5), `al_m` (6).
- Reset values:
  - `h24`, `min_r`, `sec_r`, `presc`, `al_h`, `al_m` = 0.
  - All pulse outputs = 0.
  - Outputs therefore read `hour`=0 and `pm`=0 in 24-hour mode, `hour`=12 and `pm`=0 in 12-hour mode.
- Prescaler:
  - `presc` increments every cycle.
  - When `presc == TICK_DIV-1`, it wraps to 0 and the cycle is a tick.
- On a tick:
  - `sec_r`+1; 59 wraps to 0 with a carry into `min_r`.
  - `min_r` 59 wraps to 0 with a carry into `h24`.
  - `h24` 23 wraps to 0 and asserts `day_wrap`.
- Time load (`set_valid`=1):
  - Accepted only if `set_hour`≤23, `set_min`≤59 and `set_sec`≤59.
  - On accept: time registers take the set values and `presc` clears to 0. A tick in the same cycle is discarded, so the load has priority and no `tick` is emitted.
  - On reject: state is unchanged, `set_err` pulses, and the tick proceeds normally.
- Alarm load (`alarm_wr`=1): range-checked the same way. An out-of-range value is rejected and pulses `set_err`. `alarm_wr` and `set_valid` are independent and may occur together.
- Alarm match: `alarm_hit` pulses when all of the following are true:
  - a tick advances the time to exactly `al_h`:`al_m`:00;
  - `alarm_en`=1 in that cycle.
  
  A load never triggers the alarm.
- Display mapping (combinational from registered `h24`):
  - 24-hour mode: `hour` = `h24`.
  - 12-hour mode: `h24`=0 → 12; 1–12 → unchanged; 13–23 → `h24`−12.
  - `pm` = (`h24` ≥ 12) in both modes.

## Timing
- `minute`, `second`, `tick`, `day_wrap`, `alarm_hit` and `set_err` are registered. They update on the clock edge that ends the tick, load or check cycle.
- `hour` and `pm` are combinational from registered `h24` and input `mode_24h`. A mode change is visible the same cycle, with no state change.
- First tick after reset release: the `TICK_DIV`-th clk edge after `rst` deasserts. `second` reads 1 after that edge.
- After an accepted load, the next tick occurs exactly `TICK_DIV` cycles later.
- `rst` mid-operation overrides everything, including `set_valid` and `alarm_wr` in the same cycle.
- `day_wrap` and `alarm_hit` can coincide, for an alarm at 00:00.

## Structure
- Package `rtc_pkg`:
  - constants `SEC_MAX=59`, `MIN_MAX=59`, `H24_MAX=23`;
  - field widths `HOUR_W=5`, `MS_W=6`;
  - function `to_12h(h24)` returning the display hour.
- Sub-module `rtc_prescaler` (parameters `TICK_DIV`, `CNT_W`; inputs `clk`, `rst`, `clr`; output `tick`). All remaining logic lives in `rtc_timekeeper`.

## Test plan
- Reset, then `TICK_DIV=4` free-run for 12 cycles → `second`=3, with `tick` pulses 4 cycles apart.
- Load 23:59:58, then 2 ticks → after the second tick `h24`=0, `minute`=0, `second`=0, and `day_wrap`=1 for exactly one cycle.
- Load `set_valid` with hour=24 → `set_err`=1 for one cycle and time unchanged. Repeat with sec=60 → same result.
- `mode_24h`=0 at internal 00, 12 and 13 → `hour`=12/`pm`=0, 12/1 and 1/1 respectively.
- Alarm 07:30 with `alarm_en`=1, load 07:29:59, one tick → `alarm_hit` pulses once. Repeat with `alarm_en`=0 → no pulse. Load 07:30:00 directly → no pulse.
- `set_valid` asserted in the tick cycle → no `tick`, loaded value shown, next tick `TICK_DIV` cycles later. `rst` asserted while `set_valid`=1 → all zero.
